gene_net_sweep_ctrl: RTL and testbench

Sequencer that sweeps a range of 8-bit initial values through one `gene_net` instance and classifies each run's attractor. For every initial value it loads the network, watches the state stream `x`, detects a fixed point, a cycle of period 2..HIST, or a timeout, and emits one result record per initial value over a valid/ready handshake. It sits above `gene_net`, replacing the standalone fixed-point and cycle checkers in sweep-style experiments, and keeps running totals per class.

---
 rtl/gene_net_pkg.sv | 24 ++
 rtl/gene_net_sweep_ctrl_if.sv | 38 +++
 rtl/attractor_hist.sv | 48 ++++
 rtl/gene_net_sweep_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_gene_net_sweep_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gene_net_pkg.sv
// Shared definitions for the gene_net sweep controller: state width,
// attractor class codes, controller state encoding and a counter helper.
package gene_net_pkg;

  localparam int W = 8;

  localparam logic [1:0] CLS_TIMEOUT = 2'd0;
  localparam logic [1:0] CLS_FIXED   = 2'd1;
  localparam logic [1:0] CLS_CYCLE   = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } ctrl_state_e;

  // Per-class totals stop at 256; one sweep never exceeds that.
  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'd256) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/gene_net_sweep_ctrl_if.sv
// Bundle of sweep control, network coupling and result handshake signals.
interface gene_net_sweep_ctrl_if;
  import gene_net_pkg::*;

  logic         start;
  logic         abort;
  logic [W-1:0] cfg_first;
  logic [W-1:0] cfg_last;
  logic [W-1:0] init_val;
  logic         net_load;
  logic [W-1:0] x;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_init;
  logic [1:0]   res_class;
  logic [3:0]   res_period;
  logic [7:0]   res_steps;
  logic         busy;
  logic         done;
  logic [8:0]   cnt_fixed;
  logic [8:0]   cnt_cycle;
  logic [8:0]   cnt_timeout;

  // Controller side: produces network loads and result records.
  modport master (
    input  start, abort, cfg_first, cfg_last, x, res_ready,
    output init_val, net_load, res_valid, res_init, res_class, res_period,
           res_steps, busy, done, cnt_fixed, cnt_cycle, cnt_timeout
  );

  // Environment side: requests sweeps, feeds the network state, consumes records.
  modport slave (
    output start, abort, cfg_first, cfg_last, x, res_ready,
    input  init_val, net_load, res_valid, res_init, res_class, res_period,
           res_steps, busy, done, cnt_fixed, cnt_cycle, cnt_timeout
  );

endinterface

// File: rtl/attractor_hist.sv
// History of recent network states with a parallel compare against the
// current sample; reports the smallest period that repeats.
module attractor_hist
  import gene_net_pkg::*;
#(
  parameter int HIST = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         shift_i,
  input  logic [W-1:0] x_i,
  output logic         match_o,
  output logic [3:0]   period_o
);

  logic [W-1:0]    h_q [HIST];
  logic [HIST-1:0] v_q;

  // History shift register; entry 0 is the most recent sample.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < HIST; i++) h_q[i] <= {W{1'b0}};
      v_q <= {HIST{1'b0}};
    end else if (shift_i) begin
      h_q[0] <= x_i;
      for (int i = 1; i < HIST; i++) h_q[i] <= h_q[i-1];
      v_q <= {v_q[HIST-2:0], 1'b1};
    end else begin
      v_q <= v_q;
    end
  end

  // Priority encode: scan from the deepest entry so the smallest period wins.
  always_comb begin
    match_o  = 1'b0;
    period_o = 4'd0;
    for (int k = HIST; k >= 1; k--) begin
      if (v_q[k-1] && (h_q[k-1] == x_i)) begin
        match_o  = 1'b1;
        period_o = 4'(k);
      end else begin
        match_o  = match_o;
      end
    end
  end

endmodule

// File: rtl/gene_net_sweep_ctrl.sv
// Sweeps a range of initial values through gene_net, classifies each run as
// fixed point, cycle or timeout, and reports one record per initial value.
module gene_net_sweep_ctrl
  import gene_net_pkg::*;
#(
  parameter int HIST      = 8,
  parameter int MAX_STEPS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  gene_net_sweep_ctrl_if.master bus
);

  localparam logic [7:0] MAX_STEPS_C = 8'(MAX_STEPS);

  ctrl_state_e  state_q, state_d;
  logic [W-1:0] cur_q, cur_d;
  logic [W-1:0] last_q, last_d;
  logic [7:0]   step_q, step_d;
  logic [W-1:0] res_init_q, res_init_d;
  logic [1:0]   res_class_q, res_class_d;
  logic [3:0]   res_period_q, res_period_d;
  logic [7:0]   res_steps_q, res_steps_d;
  logic [8:0]   cnt_fixed_q, cnt_fixed_d;
  logic [8:0]   cnt_cycle_q, cnt_cycle_d;
  logic [8:0]   cnt_timeout_q, cnt_timeout_d;
  logic         net_load_q, res_valid_q, busy_q, done_q;

  logic         hit_s;
  logic [3:0]   hit_period_s;
  logic [7:0]   step_inc_s;
  logic         hist_clr_s;
  logic         hist_shift_s;

  assign step_inc_s   = step_q + 8'd1;
  assign hist_clr_s   = (state_q == ST_LOAD);
  assign hist_shift_s = (state_q == ST_RUN);

  attractor_hist #(.HIST(HIST)) u_hist (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (hist_clr_s),
    .shift_i  (hist_shift_s),
    .x_i      (bus.x),
    .match_o  (hit_s),
    .period_o (hit_period_s)
  );

  // Next-state, range stepping, run classification and counter updates.
  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    last_d        = last_q;
    step_d        = step_q;
    res_init_d    = res_init_q;
    res_class_d   = res_class_q;
    res_period_d  = res_period_q;
    res_steps_d   = res_steps_q;
    cnt_fixed_d   = cnt_fixed_q;
    cnt_cycle_d   = cnt_cycle_q;
    cnt_timeout_d = cnt_timeout_q;

    if (bus.abort) begin
      // Abort beats start, res_ready and everything else; counters are kept.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d       = ST_LOAD;
            cur_d         = bus.cfg_first;
            last_d        = bus.cfg_last;
            cnt_fixed_d   = 9'd0;
            cnt_cycle_d   = 9'd0;
            cnt_timeout_d = 9'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_LOAD: begin
          step_d  = 8'd0;
          state_d = ST_RUN;
        end
        ST_RUN: begin
          step_d = step_inc_s;
          if (hit_s) begin
            // A repeat on the same sample as the step limit still counts as a detection.
            state_d      = ST_REPORT;
            res_init_d   = cur_q;
            res_class_d  = (hit_period_s == 4'd1) ? CLS_FIXED : CLS_CYCLE;
            res_period_d = hit_period_s;
            res_steps_d  = step_inc_s;
          end else if (step_inc_s == MAX_STEPS_C) begin
            state_d      = ST_REPORT;
            res_init_d   = cur_q;
            res_class_d  = CLS_TIMEOUT;
            res_period_d = 4'd0;
            res_steps_d  = MAX_STEPS_C;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_REPORT: begin
          if (bus.res_ready) begin
            case (res_class_q)
              CLS_FIXED: cnt_fixed_d   = sat_inc9(cnt_fixed_q);
              CLS_CYCLE: cnt_cycle_d   = sat_inc9(cnt_cycle_q);
              default:   cnt_timeout_d = sat_inc9(cnt_timeout_q);
            endcase
            if (cur_q == last_q) begin
              state_d = ST_DONE;
            end else begin
              cur_d   = cur_q + 8'd1;
              state_d = ST_LOAD;
            end
          end else begin
            state_d = ST_REPORT;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_q         <= {W{1'b0}};
      last_q        <= {W{1'b0}};
      step_q        <= 8'd0;
      res_init_q    <= {W{1'b0}};
      res_class_q   <= 2'd0;
      res_period_q  <= 4'd0;
      res_steps_q   <= 8'd0;
      cnt_fixed_q   <= 9'd0;
      cnt_cycle_q   <= 9'd0;
      cnt_timeout_q <= 9'd0;
      net_load_q    <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      step_q        <= step_d;
      res_init_q    <= res_init_d;
      res_class_q   <= res_class_d;
      res_period_q  <= res_period_d;
      res_steps_q   <= res_steps_d;
      cnt_fixed_q   <= cnt_fixed_d;
      cnt_cycle_q   <= cnt_cycle_d;
      cnt_timeout_q <= cnt_timeout_d;
      net_load_q    <= (state_d == ST_LOAD);
      res_valid_q   <= (state_d == ST_REPORT);
      busy_q        <= (state_d != ST_IDLE);
      done_q        <= (state_d == ST_DONE);
    end
  end

  assign bus.init_val    = cur_q;
  assign bus.net_load    = net_load_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_init    = res_init_q;
  assign bus.res_class   = res_class_q;
  assign bus.res_period  = res_period_q;
  assign bus.res_steps   = res_steps_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.cnt_fixed   = cnt_fixed_q;
  assign bus.cnt_cycle   = cnt_cycle_q;
  assign bus.cnt_timeout = cnt_timeout_q;

endmodule

// File: tb/tb_gene_net_sweep_ctrl.sv
// Directed bench for gene_net_sweep_ctrl: a scripted stub network feeds x,
// a sequence-level model predicts every result record.
module tb_gene_net_sweep_ctrl;
  import gene_net_pkg::*;

  localparam int HIST      = 8;
  localparam int MAX_STEPS = 64;

  typedef struct packed {
    logic [7:0] init;
    logic [1:0] cls;
    logic [3:0] per;
    logic [7:0] steps;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gene_net_sweep_ctrl_if bus();

  gene_net_sweep_ctrl #(.HIST(HIST), .MAX_STEPS(MAX_STEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   errors    = 0;
  int   checks    = 0;
  int   rec_cnt   = 0;
  int   bp        = 0;
  int   stub_mode = 0;
  int   stub_n    = 0;
  logic [7:0] stub_init = 8'h00;
  rec_t exp_q[$];
  rec_t last_rec;

  // Stub network sample n after a load (n = 0 is the loaded value).
  function automatic logic [7:0] stub_val(input int mode, input logic [7:0] init, input int n);
    case (mode)
      0: return init;
      1: return (n == 0) ? init : ((n % 2 == 1) ? 8'h1C : 8'h2A);
      2: return init + 8'(n);
      default: return init;
    endcase
  endfunction

  // Expected record: walk the sample sequence and look for the nearest earlier repeat.
  function automatic rec_t model_run(input int mode, input logic [7:0] init);
    logic [7:0] s [1:255];
    rec_t r;
    r.init  = init;
    r.cls   = 2'd0;
    r.per   = 4'd0;
    r.steps = 8'(MAX_STEPS);
    for (int i = 1; i <= MAX_STEPS; i++) begin
      s[i] = stub_val(mode, init, i - 1);
      for (int k = 1; k <= HIST && k < i; k++) begin
        if (s[i-k] == s[i]) begin
          r.cls   = (k == 1) ? 2'd1 : 2'd2;
          r.per   = 4'(k);
          r.steps = 8'(i);
          return r;
        end
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Stub network: reloads on net_load, otherwise steps its scripted sequence.
  always @(posedge clk) begin
    if (bus.net_load) begin
      stub_n    <= 0;
      stub_init <= bus.init_val;
      bus.x     <= bus.init_val;
    end else begin
      stub_n    <= stub_n + 1;
      bus.x     <= stub_val(stub_mode, stub_init, stub_n + 1);
    end
  end

  // Consumer: hold res_ready low for bp cycles of each record.
  initial begin : ready_drv
    int wait_cnt;
    wait_cnt = 0;
    bus.res_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!bus.res_valid) begin
        wait_cnt = 0;
        bus.res_ready = (bp == 0);
      end else if (!bus.res_ready) begin
        wait_cnt++;
        if (wait_cnt >= bp) bus.res_ready = 1'b1;
      end else begin
        bus.res_ready = 1'b1;
      end
    end
  end

  // Compare every presented record with the model queue head.
  always @(negedge clk) begin
    if (bus.res_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rec_unexpected: got init=%h cls=%0d want no record", bus.res_init, bus.res_class);
      end else begin
        if ({bus.res_init, bus.res_class, bus.res_period, bus.res_steps} !== exp_q[0]) begin
          errors++;
          $display("FAIL rec_fields: got init=%h cls=%0d per=%0d steps=%0d want init=%h cls=%0d per=%0d steps=%0d",
                   bus.res_init, bus.res_class, bus.res_period, bus.res_steps,
                   exp_q[0].init, exp_q[0].cls, exp_q[0].per, exp_q[0].steps);
        end
        if (bus.res_ready) begin
          last_rec = {bus.res_init, bus.res_class, bus.res_period, bus.res_steps};
          void'(exp_q.pop_front());
          rec_cnt++;
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_init_val"}, 32'(bus.init_val), 32'd0);
    chk({tag, "_flags"}, 32'({bus.net_load, bus.res_valid, bus.busy, bus.done}), 32'd0);
    chk({tag, "_res"}, 32'({bus.res_init, bus.res_class, bus.res_period, bus.res_steps}), 32'd0);
    chk({tag, "_cnts"}, 32'({bus.cnt_fixed, bus.cnt_cycle, bus.cnt_timeout}), 32'd0);
  endtask

  task automatic start_sweep(input logic [7:0] first, input logic [7:0] last);
    @(posedge clk); #1;
    bus.cfg_first = first;
    bus.cfg_last  = last;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  // Full sweep with ready policy bpc; returns the cycle index (1 = LOAD) of first valid and of done.
  task automatic run_sweep(input logic [7:0] first, input logic [7:0] last, input int mode,
                           input int bpc, input int ef, input int ec, input int et,
                           output int valid_idx, output int done_idx);
    int n, idx, done_seen;
    logic [7:0] c;
    stub_mode = mode;
    bp        = bpc;
    n = int'(8'(last - first)) + 1;
    c = first;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_run(mode, c));
      c = c + 8'd1;
    end
    start_sweep(first, last);
    @(negedge clk);
    idx = 1;
    chk("load_strobe", 32'(bus.net_load), 32'd1);
    chk("load_init", 32'(bus.init_val), 32'(first));
    chk("load_cnts_clear", 32'({bus.cnt_fixed, bus.cnt_cycle, bus.cnt_timeout}), 32'd0);
    valid_idx = -1;
    done_idx  = -1;
    done_seen = 0;
    while (idx < 3000) begin
      @(negedge clk);
      idx++;
      if (bus.res_valid && valid_idx < 0) valid_idx = idx;
      if (bus.done) begin
        done_seen++;
        if (done_idx < 0) done_idx = idx;
      end
      if (done_idx >= 0 && idx == done_idx + 1) break;
    end
    chk("done_pulses", 32'(done_seen), 32'd1);
    chk("idle_after", 32'(bus.busy), 32'd0);
    chk("cnt_fixed", 32'(bus.cnt_fixed), 32'(ef));
    chk("cnt_cycle", 32'(bus.cnt_cycle), 32'(ec));
    chk("cnt_timeout", 32'(bus.cnt_timeout), 32'(et));
    chk("records_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int vi, di, rc0, loads, idx, dones;
    rec_t r;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.cfg_first = 8'h00;
    bus.cfg_last  = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Model pins against hand-derived records.
    r = model_run(0, 8'h00);
    chk("model_fixed", 32'({r.cls, r.per, r.steps}), 32'({2'd1, 4'd1, 8'd2}));
    r = model_run(1, 8'h38);
    chk("model_cycle", 32'({r.cls, r.per, r.steps}), 32'({2'd2, 4'd2, 8'd4}));
    r = model_run(2, 8'h7C);
    chk("model_timeout", 32'({r.cls, r.per, r.steps}), 32'({2'd0, 4'd0, 8'd64}));

    // Single fixed point: LOAD, two samples, then report.
    run_sweep(8'h00, 8'h00, 0, 0, 1, 0, 0, vi, di);
    chk("fix_valid_cycle", 32'(vi), 32'd4);
    chk("fix_done_cycle", 32'(di), 32'd5);
    chk("fix_record", 32'(last_rec), 32'({8'h00, 2'd1, 4'd1, 8'd2}));

    // Period-2 cycle.
    run_sweep(8'h38, 8'h38, 1, 0, 0, 1, 0, vi, di);
    chk("cyc_valid_cycle", 32'(vi), 32'd6);
    chk("cyc_done_cycle", 32'(di), 32'd7);
    chk("cyc_record", 32'(last_rec), 32'({8'h38, 2'd2, 4'd2, 8'd4}));

    // Timeout on a never-repeating counter.
    run_sweep(8'h7C, 8'h7C, 2, 0, 0, 0, 1, vi, di);
    chk("to_valid_cycle", 32'(vi), 32'd66);
    chk("to_done_cycle", 32'(di), 32'd67);
    chk("to_record", 32'(last_rec), 32'({8'h7C, 2'd0, 4'd0, 8'd64}));

    // Wrap-around range under backpressure.
    rc0 = rec_cnt;
    run_sweep(8'hFE, 8'h01, 0, 5, 4, 0, 0, vi, di);
    chk("wrap_records", 32'(rec_cnt - rc0), 32'd4);
    chk("wrap_last_init", 32'(last_rec.init), 32'h01);

    // Abort during the second run.
    stub_mode = 0;
    bp = 0;
    exp_q.push_back(model_run(0, 8'h10));
    start_sweep(8'h10, 8'h13);
    loads = 0;
    idx = 0;
    while (loads < 2 && idx < 200) begin
      @(negedge clk);
      idx++;
      if (bus.net_load) loads++;
    end
    chk("abort_reach_run2", 32'(loads), 32'd2);
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'({bus.busy, bus.res_valid, bus.net_load}), 32'd0);
    dones = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);
    chk("abort_cnt_fixed", 32'(bus.cnt_fixed), 32'd1);
    chk("abort_records", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    run_sweep(8'h10, 8'h11, 0, 0, 2, 0, 0, vi, di);

    // Reset while the second record is held.
    stub_mode = 0;
    bp = 20;
    exp_q.push_back(model_run(0, 8'h40));
    exp_q.push_back(model_run(0, 8'h41));
    start_sweep(8'h40, 8'h41);
    loads = 0;
    idx = 0;
    while (loads < 2 && idx < 400) begin
      @(negedge clk);
      idx++;
      if (bus.net_load) loads++;
    end
    idx = 0;
    while (!bus.res_valid && idx < 100) begin
      @(negedge clk);
      idx++;
    end
    chk("rst_pending_valid", 32'(bus.res_valid), 32'd1);
    chk("rst_pending_cnt", 32'(bus.cnt_fixed), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset("mid_report");
    exp_q.delete();
    bp = 0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
